smc_rd_engine: RTL and testbench
================================

# smc_rd_engine

Slave-side read engine for the SMC read channel, directly downstream of the ANB read crossbar. It accepts one burst request at a time on `smc_rd_if`, issues one word read per cycle to a fixed-latency synchronous memory port, and buffers the returned words in a credit-controlled response FIFO. Each response word is tagged with the request's `aid` and `last`, which lets the crossbar steer data back to the originating master.

## Interface
- `N`, 1: number of crossbar masters; ID width is `clog2(N)` (`rd_id_t`).
- `RD_LAT`, 2: memory read latency in cycles, from `mem_rd` to `mem_rdata` valid; ≥1.
- `FIFO_DEPTH`, 4: response FIFO entries, power of two; ≥`RD_LAT+1` for full throughput.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `s`  smc_rd_if.s  —  request/response channel:
  - Inputs: `aid`, `addr` (smc_addr_t), `len` (smc_trn_max_len_t), `avalid`, `ready`.
  - Outputs: `aready`, `data` (smc_data_t), `strb` (smc_data_be_t), `id`, `valid`, `last`.
- `mem_rd`  out  1  read strobe, one word per assertion.
- `mem_addr`  out  smc_addr_t  word address; valid while `mem_rd`=1.
- `mem_rdata`  in  smc_data_t  read data; valid exactly `RD_LAT` cycles after `mem_rd`.

## Operation
- `len` = beats−1, so `len`=0 is a single beat. Address increments by 1 per beat and wraps modulo 2^width with no error.
- FSM has two states, IDLE and BURST:
  - IDLE: `aready`=1. On `avalid & aready`, latch `addr`, `len`, `aid`; load beat counter with `len`; go to BURST.
  - BURST: `aready`=0. Each cycle with `credit_ok`: assert `mem_rd`, drive `mem_addr`=cur_addr, increment cur_addr, decrement the counter.
    - The issued beat with counter==0 carries `last`=1 and returns the FSM to IDLE on the next edge.
    - A new request can be accepted one cycle after the last issue.
- Tag pipeline: a `RD_LAT`-deep shift register carries {valid, id, last} alongside each read. At its output, {`mem_rdata`, id, last} is written into the FIFO.
- Credit counter `cnt`: counts beats in flight plus FIFO occupancy, range 0..`FIFO_DEPTH`.
  - +1 on issue, −1 on pop (`s.valid & s.ready`); simultaneous issue and pop leaves `cnt` unchanged.
  - `credit_ok` = `cnt < FIFO_DEPTH`. The FIFO therefore never overflows; no write is ever dropped.
- Output side:
  - `s.valid` = FIFO not empty; `s.data`/`s.id`/`s.last` come from the FIFO head.
  - `s.strb` = all ones.
  - Data holds stable while `valid & ~ready`.
- `avalid` during BURST is ignored: `aready`=0, so the request is not consumed.

## Timing
- Reset values: `aready`=1, `mem_rd`=0, `mem_addr`=0, `s.valid`=0, `s.last`=0, `s.id`=0, `s.data`=0. FSM state = IDLE, `cnt`=0, FIFO empty, tag pipeline cleared.
- Reset asserted mid-burst: everything above clears immediately, and in-flight memory data is discarded.
- `aready` is a registered output and has no combinational path from `avalid`.
- Request handshake at edge T:
  - first `mem_rd` at cycle T+1;
  - FIFO write at edge T+1+`RD_LAT`;
  - `s.valid`=1 from cycle T+2+`RD_LAT`.
- Throughput:
  - 1 beat/cycle with `ready`=1 and `FIFO_DEPTH`≥`RD_LAT+1`.
  - Between bursts: one IDLE cycle after the last issue.
- Backpressure: issue stalls the cycle after `cnt` reaches `FIFO_DEPTH`, and resumes the cycle after a pop.

## Test plan
- Single beat: `RD_LAT`=2, `aid`=0, `addr`=0x10, `len`=0 → one `mem_rd` at 0x10; one response with `last`=1, `id`=0, data=mem[0x10], `valid` 4 cycles after the handshake.
- Burst with no backpressure: `aid`=1, `addr`=0x20, `len`=7, `ready`=1 → `mem_addr` 0x20..0x27 on 8 consecutive cycles; 8 consecutive responses, `last` only on the 8th, all `id`=1.
- Backpressure: `len`=15, `ready`=0 for 10 cycles, then 1 → at most `FIFO_DEPTH`=4 reads issued while stalled; all 16 words delivered in order with no loss or duplication; `cnt` never exceeds 4.
- Back-to-back requests: `aid`=0 `len`=3, then `aid`=1 `len`=1 held valid → second `aready` handshake exactly one cycle after the 4th `mem_rd`; responses are 4×`id`0 then 2×`id`1, each group ending with `last`=1.
- Address wrap: `addr`=all-ones, `len`=1 → `mem_addr` sequence is all-ones, then 0.
- Reset mid-burst: deassert `rst_n` during beat 3 of an 8-beat burst → `s.valid`=0, `mem_rd`=0 and `aready`=1 during reset; after release, a new `len`=0 request completes normally with no stale data.

Source files
------------

// File: rtl/smc_rd_engine_if.sv
// Request/response channel between the ANB read crossbar and the SMC read engine.
interface smc_rd_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    typedef logic [ID_W-1:0]     rd_id_t;
    typedef logic [ADDR_W-1:0]   smc_addr_t;
    typedef logic [DATA_W-1:0]   smc_data_t;
    typedef logic [DATA_W/8-1:0] smc_data_be_t;
    typedef logic [LEN_W-1:0]    smc_trn_max_len_t;

    rd_id_t           aid;
    smc_addr_t        addr;
    smc_trn_max_len_t len;
    logic             avalid;
    logic             aready;
    smc_data_t        data;
    smc_data_be_t     strb;
    rd_id_t           id;
    logic             valid;
    logic             ready;
    logic             last;

    modport s (
        input  aid, addr, len, avalid, ready,
        output aready, data, strb, id, valid, last
    );

    modport m (
        output aid, addr, len, avalid, ready,
        input  aready, data, strb, id, valid, last
    );
endinterface

// File: rtl/smc_rd_engine.sv
// SMC slave read engine: burst request -> one memory read per cycle -> credit-controlled
// response FIFO tagged with the requester id and last-beat flag.
module smc_rd_engine #(
    parameter int N          = 1,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    smc_rd_if.s               s,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int ID_W   = (N > 1) ? $clog2(N) : 1;
    localparam int STAGES = RD_LAT - 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q;
    logic [LEN_W-1:0]   beats_q;
    logic [ID_W-1:0]    id_q;
    logic [CW-1:0]      cnt_q;
    logic               aready, accept, issue, credit_ok, pop, empty;

    logic [STAGES:0]            vld_pipe, last_pipe;
    logic [STAGES:0][ID_W-1:0]  id_pipe;

    logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_data;
    logic [FIFO_DEPTH-1:0][ID_W-1:0]   fifo_id;
    logic [FIFO_DEPTH-1:0]             fifo_last;
    logic [PW:0]                       wr_ptr_q, rd_ptr_q;

    // aready decodes straight from the state flop, so avalid never reaches it combinationally
    assign aready    = (state_q == IDLE);
    assign accept    = s.avalid & aready;
    assign credit_ok = (cnt_q < DEPTH_C);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign pop       = ~empty & s.ready;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE:  if (s.avalid) state_d = BURST;
            BURST: if (credit_ok) begin
                issue = 1'b1;
                if (beats_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            beats_q    <= '0;
            id_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cur_addr_q <= s.addr;
                beats_q    <= s.len;
                id_q       <= s.aid;
            end else if (issue) begin
                cur_addr_q <= cur_addr_q + 1'b1;
                beats_q    <= beats_q - 1'b1;
            end
        end
    end

    // Credits cover beats in flight plus FIFO occupancy, so the FIFO can never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            id_pipe   <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= issue & (beats_q == '0);
            id_pipe[0]   <= id_q;
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                id_pipe[i]   <= id_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (vld_pipe[STAGES]) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)              rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[STAGES]) begin
            fifo_data[wr_ptr_q[PW-1:0]] <= mem_rdata;
            fifo_id[wr_ptr_q[PW-1:0]]   <= id_pipe[STAGES];
            fifo_last[wr_ptr_q[PW-1:0]] <= last_pipe[STAGES];
        end
    end

    // Head is masked while empty so outputs read zero out of reset regardless of storage contents.
    assign s.aready = aready;
    assign s.valid  = ~empty;
    assign s.data   = empty ? '0 : fifo_data[rd_ptr_q[PW-1:0]];
    assign s.id     = empty ? '0 : fifo_id[rd_ptr_q[PW-1:0]];
    assign s.last   = ~empty & fifo_last[rd_ptr_q[PW-1:0]];
    assign s.strb   = '1;
    assign mem_rd   = issue;
    assign mem_addr = cur_addr_q;
endmodule

// File: tb/tb_smc_rd_engine.sv
// Scoreboard bench for smc_rd_engine: directed bursts, backpressure, wrap and mid-burst reset.
module tb_smc_rd_engine;
    localparam int N = 2, RD_LAT = 2, FIFO_DEPTH = 4, ADDR_W = 16, DATA_W = 32, LEN_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [0:0]        id;
        logic              last;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    smc_rd_if #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) s_if ();

    smc_rd_engine #(.N(N), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH),
                    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .s(s_if),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 16'hA5A5, a};
    endfunction

    // Fixed-latency memory model
    logic [RD_LAT-1:0]             rp_vld = '0;
    logic [RD_LAT-1:0][ADDR_W-1:0] rp_addr = '0;
    always @(posedge clk) begin
        rp_vld  <= {rp_vld[RD_LAT-2:0], mem_rd};
        rp_addr <= {rp_addr[RD_LAT-2:0], mem_addr};
    end
    assign mem_rdata = rp_vld[RD_LAT-1] ? mem_word(rp_addr[RD_LAT-1]) : 32'hDEAD_BEEF;

    int total = 0, bad = 0;
    rsp_t              rsp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int n_rd = 0, outstanding = 0;
    int first_rd_cyc = -1, last_rd_cyc = -1, first_vld_cyc = -1, last_pop_cyc = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    // Monitor: pops the scoreboards whenever the DUT issues a read or delivers a word
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                n_rd++;
                last_rd_cyc = cyc;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                outstanding++;
                chk("credit_limit", 64'(outstanding <= FIFO_DEPTH), 64'd1);
                if (addr_q.size() == 0) fail_now("rd_extra");
                else chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
            if (s_if.valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (s_if.valid && s_if.ready) begin
                rsp_t e;
                outstanding--;
                last_pop_cyc = cyc;
                if (rsp_q.size() == 0) fail_now("rsp_extra");
                else begin
                    e = rsp_q.pop_front();
                    chk("rsp_data", 64'(s_if.data), 64'(e.d));
                    chk("rsp_id",   64'(s_if.id),   64'(e.id));
                    chk("rsp_last", 64'(s_if.last), 64'(e.last));
                    chk("rsp_strb", 64'(s_if.strb), 64'hF);
                end
            end
        end
    end

    task automatic send(input int id, input int a, input int l, input bit hold, output int hs);
        int n = 0;
        logic [ADDR_W-1:0] aa;
        s_if.aid    = 1'(id);
        s_if.addr   = ADDR_W'(a);
        s_if.len    = LEN_W'(l);
        s_if.avalid = 1'b1;
        @(negedge clk);
        while (!s_if.aready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("handshake_timeout");
            s_if.avalid = 1'b0;
            hs = -1;
            return;
        end
        aa = ADDR_W'(a);
        for (int i = 0; i <= l; i++) begin
            addr_q.push_back(aa);
            rsp_q.push_back(rsp_t'{d: mem_word(aa), id: 1'(id), last: (i == l)});
            aa = aa + 1'b1;
        end
        @(posedge clk);
        #1;
        hs = cyc;
        if (!hold) s_if.avalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || addr_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_time", 64'(n < 400), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_marks();
        n_rd = 0;
        first_rd_cyc = -1;
        first_vld_cyc = -1;
        last_pop_cyc = -1;
    endtask

    int hs, hs2, rd_before;

    initial begin
        s_if.avalid = 1'b0;
        s_if.aid    = '0;
        s_if.addr   = '0;
        s_if.len    = '0;
        s_if.ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_aready", 64'(s_if.aready), 64'd1);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_valid", 64'(s_if.valid), 64'd0);
        chk("rst_last", 64'(s_if.last), 64'd0);
        chk("rst_id", 64'(s_if.id), 64'd0);
        chk("rst_data", 64'(s_if.data), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single beat: first read the cycle after handshake, valid RD_LAT+2 edges after it
        clear_marks();
        send(0, 16'h0010, 0, 1'b0, hs);
        drain();
        chk("t1_first_rd", 64'(first_rd_cyc), 64'(hs));
        chk("t1_valid_lat", 64'(first_vld_cyc), 64'(hs + RD_LAT + 1));
        chk("t1_n_rd", 64'(n_rd), 64'd1);

        // 8-beat burst, no backpressure
        clear_marks();
        send(1, 16'h0020, 7, 1'b0, hs);
        drain();
        chk("t2_n_rd", 64'(n_rd), 64'd8);
        chk("t2_rd_span", 64'(last_rd_cyc - first_rd_cyc), 64'd7);
        chk("t2_rsp_span", 64'(last_pop_cyc - first_vld_cyc), 64'd7);

        // backpressure: reads stop once the credits are used up
        clear_marks();
        s_if.ready = 1'b0;
        send(0, 16'h0030, 15, 1'b0, hs);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_stalled_rd", 64'(n_rd), 64'(FIFO_DEPTH));
        chk("t3_stalled_valid", 64'(s_if.valid), 64'd1);
        s_if.ready = 1'b1;
        drain();
        chk("t3_n_rd", 64'(n_rd), 64'd16);

        // back-to-back requests with avalid held
        clear_marks();
        send(0, 16'h0040, 3, 1'b1, hs);
        send(1, 16'h0048, 1, 1'b0, hs2);
        rd_before = n_rd;
        chk("t4_first_burst_rd", 64'(rd_before), 64'd4);
        chk("t4_second_hs", 64'(hs2), 64'(last_rd_cyc + 2));
        drain();
        chk("t4_n_rd", 64'(n_rd), 64'd6);

        // address wrap
        clear_marks();
        send(1, 16'hFFFF, 1, 1'b0, hs);
        drain();
        chk("t5_n_rd", 64'(n_rd), 64'd2);

        // reset during beat 3 of an 8-beat burst
        clear_marks();
        send(1, 16'h0060, 7, 1'b0, hs);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_pre_reset_rd", 64'(mem_rd), 64'd1);
        rst_n = 1'b0;
        rsp_q.delete();
        addr_q.delete();
        outstanding = 0;
        @(negedge clk);
        chk("t6_rst_valid", 64'(s_if.valid), 64'd0);
        chk("t6_rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("t6_rst_aready", 64'(s_if.aready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_marks();
        send(0, 16'h0070, 0, 1'b0, hs);
        drain();
        repeat (10) @(posedge clk);
        #1;
        chk("t6_n_rd", 64'(n_rd), 64'd1);
        chk("t6_valid_lat", 64'(first_vld_cyc), 64'(hs + RD_LAT + 1));
        chk("end_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("end_idle_valid", 64'(s_if.valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
